// File: rtl/cp0_unit.sv
// Coprocessor-0 for the five-stage MIPS core: Status/Cause/EPC/BadVAddr/Count/Compare,
// with exception, interrupt and ERET resolution at the commit (WB) stage.
module cp0_unit #(
    parameter int unsigned INT_LINES   = 6,
    parameter int unsigned TIMER_DIV   = 2,
    parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
    parameter logic [31:0] COUNT_RESET = 32'h0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [INT_LINES-1:0] ext_int,
    input  logic                 cm_valid,
    input  logic [31:0]          cm_pc,
    input  logic                 cm_bd,
    input  logic                 cm_ex,
    input  logic [4:0]           cm_excode,
    input  logic [31:0]          cm_badvaddr,
    input  logic                 cm_eret,
    input  logic                 cm_mtc0,
    input  logic [4:0]           cm_rd,
    input  logic [2:0]           cm_sel,
    input  logic [31:0]          cm_wdata,
    output logic [31:0]          rdata,
    output logic                 ex_taken,
    output logic                 flush,
    output logic [31:0]          flush_pc,
    output logic                 int_pending,
    output logic                 status_exl
);

    localparam int unsigned      PRE_W    = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TIMER_DIV - 1);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    // Architectural state
    logic [7:0]       st_im;
    logic             st_exl;
    logic             st_ie;
    logic             ca_bd;
    logic             ca_ti;
    logic [5:0]       ca_ip_hw;
    logic [1:0]       ca_ip_sw;
    logic [4:0]       ca_exc;
    logic [31:0]      epc;
    logic [31:0]      badvaddr;
    logic [31:0]      count;
    logic [31:0]      compare;
    logic [PRE_W-1:0] prescale;

    // Commit-stage decode
    logic [7:0]  ip;
    logic [31:0] status_word;
    logic [31:0] cause_word;
    logic [4:0]  exc_code;
    logic        eret_go;
    logic        mtc0_go;
    logic        wr_count;
    logic        wr_compare;
    logic        wr_status;
    logic        wr_cause;
    logic        wr_epc;
    logic        timer_tick;
    logic        timer_match;
    logic        first_exc;

    // Timer interrupt shares IP[7] with the top hardware line
    assign ip          = {ca_ip_hw[5] | ca_ti, ca_ip_hw[4:0], ca_ip_sw};
    assign status_word = {9'd0, 1'b1, 6'd0, st_im, 6'd0, st_exl, st_ie};
    assign cause_word  = {ca_bd, ca_ti, 14'd0, ip, 1'b0, ca_exc, 2'b00};

    assign int_pending = (|(ip & st_im)) & st_ie & ~st_exl;
    assign ex_taken    = cm_valid & (cm_ex | int_pending);
    assign exc_code    = cm_ex ? cm_excode : 5'd0;
    assign first_exc   = ex_taken & ~st_exl;
    assign eret_go     = cm_valid & cm_eret & ~ex_taken;
    assign mtc0_go     = cm_valid & cm_mtc0 & ~cm_eret & ~ex_taken & (cm_sel == 3'd0);

    assign wr_count    = mtc0_go & (cm_rd == REG_COUNT);
    assign wr_compare  = mtc0_go & (cm_rd == REG_COMPARE);
    assign wr_status   = mtc0_go & (cm_rd == REG_STATUS);
    assign wr_cause    = mtc0_go & (cm_rd == REG_CAUSE);
    assign wr_epc      = mtc0_go & (cm_rd == REG_EPC);

    assign flush       = ex_taken | eret_go;
    assign flush_pc    = ex_taken ? EXC_VECTOR : epc;
    assign status_exl  = st_exl;

    assign timer_tick  = (prescale == PRE_LAST);
    assign timer_match = (count == compare);

    // MFC0 read port; any non-zero select reads as zero
    always_comb begin
        rdata = 32'd0;
        if (cm_sel == 3'd0) begin
            case (cm_rd)
                REG_BADVADDR: rdata = badvaddr;
                REG_COUNT:    rdata = count;
                REG_COMPARE:  rdata = compare;
                REG_STATUS:   rdata = status_word;
                REG_CAUSE:    rdata = cause_word;
                REG_EPC:      rdata = epc;
                default:      rdata = 32'd0;
            endcase
        end
    end

    // Status: exception entry sets EXL, ERET clears it, MTC0 writes IM/EXL/IE
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st_im  <= 8'd0;
            st_exl <= 1'b0;
            st_ie  <= 1'b0;
        end else if (ex_taken) begin
            st_exl <= 1'b1;
        end else if (eret_go) begin
            st_exl <= 1'b0;
        end else if (wr_status) begin
            st_im  <= cm_wdata[15:8];
            st_exl <= cm_wdata[1];
            st_ie  <= cm_wdata[0];
        end
    end

    // Cause: hardware IP sampled every cycle, BD/ExcCode on exception, IP[1:0] by MTC0
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ca_bd    <= 1'b0;
            ca_ip_hw <= 6'd0;
            ca_ip_sw <= 2'd0;
            ca_exc   <= 5'd0;
        end else begin
            ca_ip_hw <= 6'(ext_int);
            if (ex_taken) begin
                ca_exc <= exc_code;
                if (!st_exl) begin
                    ca_bd <= cm_bd;
                end
            end
            if (wr_cause) begin
                ca_ip_sw <= cm_wdata[9:8];
            end
        end
    end

    // Timer interrupt flag: a Compare write in the matching cycle wins
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ca_ti <= 1'b0;
        end else if (wr_compare) begin
            ca_ti <= 1'b0;
        end else if (timer_match) begin
            ca_ti <= 1'b1;
        end
    end

    // EPC and BadVAddr are only captured on the first (EXL = 0) exception
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            epc      <= 32'd0;
            badvaddr <= 32'd0;
        end else begin
            if (first_exc) begin
                epc <= cm_bd ? (cm_pc - 32'd4) : cm_pc;
            end else if (wr_epc) begin
                epc <= cm_wdata;
            end
            if (first_exc && ((exc_code == 5'd4) || (exc_code == 5'd5))) begin
                badvaddr <= cm_badvaddr;
            end
        end
    end

    // Count with prescaler; an MTC0 to Count overrides the increment
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count    <= COUNT_RESET;
            prescale <= '0;
        end else if (wr_count) begin
            count    <= cm_wdata;
            prescale <= '0;
        end else if (timer_tick) begin
            count    <= count + 32'd1;
            prescale <= '0;
        end else begin
            prescale <= prescale + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            compare <= 32'hFFFF_FFFF;
        end else if (wr_compare) begin
            compare <= cm_wdata;
        end
    end

endmodule
